// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle PC sequencing controller.
// Walks each instruction through IF/ID/EXE/MEM/WB and drives the
// strobes that steer the PC-source mux, the IR, memory and register file.
// Illegal opcodes park the controller in HALT until reset.
// Outputs are decoded combinationally from the current state and inputs,
// and are all forced to zero while rst is high.
module pc_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] pc_sel,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       rf_we,
  output logic       link,
  output logic [2:0] state,
  output logic       halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_RS     = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  state_e state_q, state_d;

  logic is_j, is_jal, is_jr, is_jump, is_beq, is_bne, is_branch;
  logic is_lw, is_sw, is_mem, is_alu_i, is_rtype_alu, is_legal_exe;
  logic br_taken;

  // Instruction class decode, used from ID onward
  always_comb begin
    is_j         = (opcode == OP_J);
    is_jal       = (opcode == OP_JAL);
    is_jr        = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_jump      = is_j || is_jal || is_jr;
    is_beq       = (opcode == OP_BEQ);
    is_bne       = (opcode == OP_BNE);
    is_branch    = is_beq || is_bne;
    is_lw        = (opcode == OP_LW);
    is_sw        = (opcode == OP_SW);
    is_mem       = is_lw || is_sw;
    is_alu_i     = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                   (opcode == OP_ORI)  || (opcode == OP_SLTI) ||
                   (opcode == OP_LUI);
    is_rtype_alu = (opcode == OP_RTYPE) && (funct != FN_JR);
    is_legal_exe = is_rtype_alu || is_alu_i || is_branch || is_mem;
    br_taken     = (is_beq && zero) || (is_bne && !zero);
  end

  // State register with synchronous reset back to IF
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        if (is_jump)           state_d = S_IF;
        else if (is_legal_exe) state_d = S_EXE;
        else                   state_d = S_HALT;
      end
      S_EXE: begin
        if (is_branch)   state_d = S_IF;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = is_sw ? S_IF : S_WB;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    pc_sel  = PC_SEQ;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    link    = 1'b0;
    halted  = 1'b0;
    state   = rst ? 3'(S_IF) : 3'(state_q);
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_ID: begin
          if (is_j || is_jal) begin
            pc_we  = 1'b1;
            pc_sel = PC_JUMP;
            rf_we  = is_jal;
            link   = is_jal;
          end else if (is_jr) begin
            pc_we  = 1'b1;
            pc_sel = PC_RS;
          end
        end
        S_EXE: begin
          if (br_taken) begin
            pc_we  = 1'b1;
            pc_sel = PC_BRANCH;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_sw;
        end
        S_WB:    rf_we  = 1'b1;
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have: clk  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: opcode  input  6  instruction bits [31:26], valid from ID onward.
REQ-004 SHALL have: funct  input  6  instruction bits [5:0], valid from ID onward.
REQ-005 SHALL have: zero  input  1  ALU zero flag, valid in EXE.
REQ-006 SHALL have: mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 SHALL have: pc_sel  output  2  choose code for the PC-source 4:1 mux: 00 sequential (Y), 01 RS, 10 jump (II), 11 branch (ext_addr).
REQ-008 SHALL have: pc_we, ir_we, mem_req, mem_we, rf_we  output  1 each  PC write, IR write, memory request, memory write, register-file write.
REQ-009 SHALL have: link  output  1  jal: register-file destination forced to $31, data = PC.
REQ-010 SHALL have: state  output  3  current FSM state; halted  output  1  high in HALT.

Function
REQ-011 SHALL implement a registered FSM: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111; outputs combinational from state, opcode, funct, zero, mem_ready.
REQ-012 SHALL drive pc_sel=00 and all strobes 0 in every cycle not listed below.
REQ-013 IF: mem_req=1; if mem_ready=0 stay IF; if mem_ready=1 assert ir_we=1, pc_we=1, pc_sel=00 and go to ID.
REQ-014 ID, decode: j (000010): pc_we=1, pc_sel=10, go IF; jal (000011): pc_we=1, pc_sel=10, rf_we=1, link=1, go IF; jr (opcode 000000, funct 001000): pc_we=1, pc_sel=01, go IF.
REQ-015 ID, other legal opcodes (R-type 000000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, lui 001111, lw 100011, sw 101011): go EXE with no strobes.
REQ-016 ID, opcode 111111 or any opcode not in REQ-014/015: go HALT, no strobes.
REQ-017 EXE: beq with zero=1 or bne with zero=0: pc_we=1, pc_sel=11; beq/bne always go IF next.
REQ-018 EXE: lw/sw go MEM; R-type and I-type ALU go WB; no strobes in EXE except REQ-017.
REQ-019 MEM: mem_req=1, mem_we=1 for sw only; hold MEM while mem_ready=0; on mem_ready=1 sw goes IF, lw goes WB.
REQ-020 WB: rf_we=1 for exactly one cycle, then IF.
REQ-021 HALT: halted=1, all strobes 0, remain in HALT until rst.
REQ-022 pc_we SHALL be asserted at most once per instruction except jal/j/jr/branch-taken, where it is asserted exactly twice (IF increment plus redirect).
REQ-023 mem_ready SHALL be ignored in ID, EXE, WB, HALT.
REQ-024 Instruction latency: j/jal/jr 2+w cycles, beq/bne 3+w, ALU 4+w, sw 4+w+m, lw 5+w+m (w, m = IF and MEM wait cycles).

Reset
REQ-025 When rst=1 at a rising edge, state SHALL become IF, from any state including mid-MEM wait and HALT.
REQ-026 While rst=1 all outputs SHALL be 0 (pc_sel=00, state reported as IF=000, halted=0); mem_req rises only in the first cycle with rst=0.
REQ-027 No memory or register write SHALL occur in the cycle rst is asserted.

Verification
REQ-028 add (opcode 0, funct 100000), mem_ready=1 always -> states IF,ID,EXE,WB,IF; pc_we only in IF; rf_we=1 only in WB.
REQ-029 beq with zero=1 -> pc_we=1, pc_sel=11 in EXE; repeat with zero=0 -> pc_we=0 in EXE; bne mirror.
REQ-030 jal -> in ID pc_we=1, pc_sel=10, rf_we=1, link=1; jr (funct 001000) -> pc_sel=01 in ID.
REQ-031 lw with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB rf_we=1; sw same stall -> mem_we=1 throughout, returns IF, rf_we never 1.
REQ-032 opcode 111111 -> HALT, halted=1 for 10 cycles with no strobes; rst pulse -> IF, mem_req=1 next cycle.
REQ-033 rst asserted during MEM stall of sw -> mem_we=0 same cycle, state=IF after edge, no WB.
